// File: rtl/ov5640_pkg.sv
// ---------------------------------------------------------------------------
// ov5640_pkg
// Shared definitions for the OV5640 SCCB register-write controller.
//   - DEV_ADDR_DEFAULT : SCCB write address byte of the OV5640 (0x3C << 1).
//   - sccb_state_t     : controller FSM state encoding.
//   - Phase/bit/byte geometry of one register write (4 phases per bit slot,
//     8 data bits per byte, 4 bytes per write).
// ---------------------------------------------------------------------------
package ov5640_pkg;

  localparam logic [7:0] DEV_ADDR_DEFAULT = 8'h78;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_BYTE,
    ST_ACK,
    ST_STOP,
    ST_DONE
  } sccb_state_t;

  localparam int PHASES          = 4;
  localparam int BITS_PER_BYTE   = 8;
  localparam int BYTES_PER_WRITE = 4;
  localparam int SHIFT_W         = BITS_PER_BYTE * BYTES_PER_WRITE;

  localparam logic [1:0] PHASE_LAST = 2'(PHASES - 1);
  localparam logic [2:0] BIT_LAST   = 3'(BITS_PER_BYTE - 1);
  localparam logic [1:0] BYTE_LAST  = 2'(BYTES_PER_WRITE - 1);

endpackage

// File: rtl/ov5640_sccb_ctrl.sv
// ---------------------------------------------------------------------------
// ov5640_sccb_ctrl
// Writes one OV5640 register over SCCB per cfg_start request:
//   START, DEV_ADDR, reg_addr[15:8], reg_addr[7:0], reg_val, STOP.
// Every bit slot (and START/STOP) is four sys_clk phases, so a 1 MHz sys_clk
// gives a 250 kHz SCL. All outputs are registered, so the bus waveform trails
// the FSM state by one cycle.
//
// Ports
//   sys_clk    in   1 MHz configuration clock
//   sys_rst_n  in   asynchronous active-low reset
//   cfg_start  in   one-cycle write request (accepted only in IDLE)
//   cfg_data   in   {reg_addr[15:0], reg_val[7:0]}, latched on acceptance
//   cfg_end    out  one-cycle pulse when a write has completed
//   busy       out  transaction in progress
//   ack_err    out  sticky: some ACK slot read high (cleared only by reset)
//   scl        out  SCCB clock, push-pull
//   sda_o      out  SDA drive value, constant 0 (open-drain emulation)
//   sda_oe     out  SDA output enable, 1 = pull low
//   sda_i      in   sampled SDA pad value
// ---------------------------------------------------------------------------
module ov5640_sccb_ctrl
  import ov5640_pkg::*;
#(
  parameter logic [7:0] DEV_ADDR = DEV_ADDR_DEFAULT
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        cfg_start,
  input  logic [23:0] cfg_data,
  output logic        cfg_end,
  output logic        busy,
  output logic        ack_err,
  output logic        scl,
  output logic        sda_o,
  output logic        sda_oe,
  input  logic        sda_i
);

  sccb_state_t        state, state_nxt;
  logic [1:0]         phase, phase_nxt;
  logic [2:0]         bit_idx, bit_idx_nxt;
  logic [1:0]         byte_idx, byte_idx_nxt;
  logic [SHIFT_W-1:0] shift_src;

  logic accept;
  logic phase_last;

  // Decoded bus values for the current state/phase, registered below
  logic scl_p0, sda_oe_p0, busy_p0, cfg_end_p0, ack_smp_p0;
  logic ack_smp_p1;

  assign accept     = (state == ST_IDLE) && cfg_start;
  assign phase_last = (phase == PHASE_LAST);

  // ---- FSM state and counters ----
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= ST_IDLE;
      phase    <= 2'd0;
      bit_idx  <= 3'd0;
      byte_idx <= 2'd0;
    end else begin
      state    <= state_nxt;
      phase    <= phase_nxt;
      bit_idx  <= bit_idx_nxt;
      byte_idx <= byte_idx_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    phase_nxt    = 2'd0;
    bit_idx_nxt  = bit_idx;
    byte_idx_nxt = byte_idx;
    case (state)
      ST_IDLE: begin
        if (cfg_start) state_nxt = ST_START;
      end
      ST_START: begin
        phase_nxt = phase + 2'd1;
        if (phase_last) state_nxt = ST_BYTE;
      end
      ST_BYTE: begin
        phase_nxt = phase + 2'd1;
        if (phase_last) begin
          if (bit_idx == BIT_LAST) begin
            state_nxt   = ST_ACK;
            bit_idx_nxt = 3'd0;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end
      end
      ST_ACK: begin
        phase_nxt = phase + 2'd1;
        if (phase_last) begin
          if (byte_idx == BYTE_LAST) begin
            state_nxt    = ST_STOP;
            byte_idx_nxt = 2'd0;
          end else begin
            state_nxt    = ST_BYTE;
            byte_idx_nxt = byte_idx + 2'd1;
          end
        end
      end
      ST_STOP: begin
        phase_nxt = phase + 2'd1;
        if (phase_last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        // A cfg_start seen here is dropped; only IDLE accepts requests.
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Payload shift source: loaded on acceptance, then shifted once per data
  // bit so the current bit is always the MSB. Data path only, no reset.
  always_ff @(posedge sys_clk) begin
    if (accept) begin
      shift_src <= {DEV_ADDR, cfg_data};
    end else if ((state == ST_BYTE) && phase_last) begin
      shift_src <= {shift_src[SHIFT_W-2:0], 1'b0};
    end
  end

  // ---- stage p0: decode bus levels from state/phase ----
  always_comb begin
    scl_p0     = 1'b1;
    sda_oe_p0  = 1'b0;
    busy_p0    = 1'b1;
    cfg_end_p0 = 1'b0;
    ack_smp_p0 = 1'b0;
    case (state)
      ST_IDLE: begin
        busy_p0 = 1'b0;
      end
      ST_START: begin
        // SDA falls at p1 while SCL is high, SCL drops at p3.
        scl_p0    = (phase != PHASE_LAST);
        sda_oe_p0 = (phase != 2'd0);
      end
      ST_BYTE: begin
        scl_p0    = (phase == 2'd1) || (phase == 2'd2);
        sda_oe_p0 = ~shift_src[SHIFT_W-1];
      end
      ST_ACK: begin
        scl_p0     = (phase == 2'd1) || (phase == 2'd2);
        ack_smp_p0 = (phase == 2'd2);
      end
      ST_STOP: begin
        // SCL rises at p1, SDA is released at p2 while SCL is high.
        scl_p0    = (phase != 2'd0);
        sda_oe_p0 = (phase == 2'd0) || (phase == 2'd1);
      end
      ST_DONE: begin
        cfg_end_p0 = 1'b1;
      end
      default: begin
        busy_p0 = 1'b0;
      end
    endcase
  end

  // ---- stage p1: registered outputs ----
  // ack_err samples sda_i at the end of the cycle in which the pins show
  // ACK p2, i.e. while SCL is high and the slave holds its ACK level.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      scl        <= 1'b1;
      sda_oe     <= 1'b0;
      sda_o      <= 1'b0;
      busy       <= 1'b0;
      cfg_end    <= 1'b0;
      ack_err    <= 1'b0;
      ack_smp_p1 <= 1'b0;
    end else begin
      scl        <= scl_p0;
      sda_oe     <= sda_oe_p0;
      sda_o      <= 1'b0;
      busy       <= busy_p0;
      cfg_end    <= cfg_end_p0;
      ack_smp_p1 <= ack_smp_p0;
      ack_err    <= ack_err | (ack_smp_p1 & sda_i);
    end
  end

endmodule

// File: doc/ov5640_sccb_ctrl.md
OV5640_SCCB_CTRL -- requirements
Module: ov5640_sccb_ctrl

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 8'h78, which is the OV5640 SCCB write address byte (7-bit 0x3C, R/W=0).
REQ-002 SHALL have port sys_clk, input, 1 bit: the 1 MHz configuration clock, shared with the register-sequencer stage.
REQ-003 SHALL have port sys_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port cfg_start, input, 1 bit: single-cycle request to write one register.
REQ-005 SHALL have port cfg_data, input, 24 bits: {reg_addr[15:0], reg_val[7:0]}.
REQ-006 SHALL have port cfg_end, output, 1 bit: single-cycle pulse when a write has completed.
REQ-007 SHALL have port busy, output, 1 bit: high while a transaction is in progress.
REQ-008 SHALL have port ack_err, output, 1 bit: sticky flag, set when any ACK slot reads high.
REQ-009 SHALL have port scl, output, 1 bit: SCCB clock, driven push-pull.
REQ-010 SHALL have port sda_o, output, 1 bit: SDA drive value, always 0.
REQ-011 SHALL have port sda_oe, output, 1 bit: SDA output enable (1 = pull low, 0 = release).
REQ-012 SHALL have port sda_i, input, 1 bit: sampled SDA pad value.

Function
REQ-013 SHALL accept cfg_start only in IDLE, and SHALL ignore cfg_start while busy=1.
REQ-014 SHALL latch cfg_data into an internal shift source on the accepting cycle, so that later cfg_data changes have no effect on the transaction in progress.
REQ-015 SHALL use FSM states IDLE, START, BYTE, ACK, STOP, DONE.
- IDLE->START on an accepted cfg_start.
- START->BYTE after 4 cycles.
- BYTE->ACK after 8 bits.
- ACK->BYTE while byte_idx<3.
- ACK->STOP when byte_idx==3.
- STOP->DONE after 4 cycles.
- DONE->IDLE after 1 cycle.
REQ-016 SHALL divide every bit slot (and START/STOP) into 4 sys_clk phases via a 2-bit phase counter, giving a 250 kHz SCL.
REQ-017 SHALL drive each data bit as follows:
- p0: scl=0, SDA set up.
- p1: scl=1.
- p2: scl=1, SDA sampled during ACK.
- p3: scl=0.
REQ-018 START SHALL sequence as follows:
- p0: scl=1, SDA released.
- p1: SDA low with scl=1.
- p2: hold.
- p3: scl=0.
REQ-019 STOP SHALL sequence as follows:
- p0: scl=0, SDA low.
- p1: scl=1.
- p2: SDA released with scl=1.
- p3: hold.
REQ-020 SHALL send four bytes MSB first: DEV_ADDR, reg_addr[15:8], reg_addr[7:0], reg_val.
REQ-021 SHALL release SDA (sda_oe=0) during every ACK slot.
REQ-022 SHALL set ack_err if sda_i==1 at ACK p2, and SHALL still complete the transaction.
REQ-023 SHALL hold ack_err until reset.
REQ-024 SHALL time a transaction as 4 (START) + 4×9×4 (bytes) + 4 (STOP) = 152 cycles, starting the cycle after acceptance.
REQ-025 SHALL assert cfg_end (DONE) for exactly 1 cycle, 153 cycles after the accepting edge.
REQ-026 SHALL drive busy=1 from the cycle after acceptance through DONE inclusive.
REQ-027 SHALL accept a cfg_start that arrives the cycle after cfg_end, i.e. in IDLE, giving back-to-back writes with 1 idle cycle.
REQ-028 SHALL return to IDLE from DONE even if cfg_start is high in DONE; that request SHALL be dropped, because the sequencer never issues cfg_start there.
REQ-029 SHALL hold scl=1 and sda_oe=0 in IDLE.

Reset
REQ-030 SHALL apply the following on sys_rst_n low, asynchronously and including mid-transaction:
- state=IDLE, phase=0, bit/byte counters 0;
- scl=1, sda_oe=0, sda_o=0;
- cfg_end=0, busy=0, ack_err=0.
REQ-031 SHALL not attempt bus recovery after a mid-transaction reset; the sequencer's software-reset write re-establishes the bus.

Structure
REQ-032 SHALL place DEV_ADDR default, the FSM state encoding, and the phase/bit-count constants (4 phases, 8 bits, 4 bytes) in shared package ov5640_pkg.
REQ-033 SHALL be implemented as a single module with no sub-module; all outputs SHALL be registered.

Verification
REQ-034 Bench SHALL cover a basic write: cfg_start with cfg_data=24'h300882 and the slave ACKing -> bus decodes to bytes 78,30,08,82; cfg_end pulses at cycle 153; ack_err=0.
REQ-035 Bench SHALL cover NACK handling: slave NACKs byte 2 (8'h30) -> ack_err=1, all four bytes and STOP are still sent, and cfg_end still fires.
REQ-036 Bench SHALL cover data stability: cfg_data changed to 24'h3017ff at cycle 10 -> bus still carries 30,08,82.
REQ-037 Bench SHALL cover a request while busy: cfg_start pulse at cycle 50 -> ignored; exactly one cfg_end is produced.
REQ-038 Bench SHALL cover back-to-back writes: three writes, each issued the cycle after cfg_end -> three correct transactions, each 154 cycles apart.
REQ-039 Bench SHALL cover reset mid-transaction: sys_rst_n low at cycle 70 -> scl=1, sda_oe=0, busy=0 immediately; a subsequent cfg_start completes normally.
